seven_seg_reader: RTL

Sequential reader for the multiplexed, active-low seven-segment display bus driven by our hex-to-segment decoders. It watches the shared segment lines and the active-low digit enables and waits for each digit dwell to settle. It then maps each segment pattern back to its 4-bit hex value and assembles a 16-bit word once all four digit slots have been read. It sits on the board-test / self-check path, closing the loop on the display drivers.

---
 rtl/seven_seg_reader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_reader.sv
// Reads back a multiplexed active-low 7-segment bus and rebuilds the 16-bit hex word
// once all four digit slots have each held a stable pattern for SETTLE samples.
module seven_seg_reader #(
   parameter int unsigned SETTLE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] value,
   output logic [3:0]  blank,
   output logic        err,
   output logic        valid
);

   typedef enum logic [1:0] {IDLE, SETTLING, HELD} state_t;

   localparam logic [7:0] CNT_MAX = 8'(SETTLE);
   localparam logic [7:0] CNT_CAP = 8'(SETTLE - 1);

   state_t      state_q, state_d;
   logic [6:0]  s_seg_q, s_seg_d;
   logic [3:0]  s_an_q, s_an_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  seen_q, seen_d;
   logic [15:0] work_q, work_d;
   logic [3:0]  wblank_q, wblank_d;
   logic        scan_err_q, scan_err_d;
   logic [15:0] value_q, value_d;
   logic [3:0]  blank_q, blank_d;
   logic        err_q, err_d;
   logic        valid_q, valid_d;

   logic        changed, legal, capture;
   logic [3:0]  slot_oh, seen_all;
   logic [3:0]  dec_nib;
   logic        dec_blank, dec_bad;

   always_comb begin
      dec_nib   = 4'h0;
      dec_blank = 1'b0;
      dec_bad   = 1'b0;
      unique case (s_seg_d)
         7'h40: dec_nib = 4'h0;
         7'h79: dec_nib = 4'h1;
         7'h24: dec_nib = 4'h2;
         7'h30: dec_nib = 4'h3;
         7'h19: dec_nib = 4'h4;
         7'h12: dec_nib = 4'h5;
         7'h02: dec_nib = 4'h6;
         7'h78: dec_nib = 4'h7;
         7'h00: dec_nib = 4'h8;
         7'h10: dec_nib = 4'h9;
         7'h08: dec_nib = 4'hA;
         7'h03: dec_nib = 4'hB;
         7'h46: dec_nib = 4'hC;
         7'h21: dec_nib = 4'hD;
         7'h06: dec_nib = 4'hE;
         7'h0E: dec_nib = 4'hF;
         7'h7F: dec_blank = 1'b1;
         default: dec_bad = 1'b1;
      endcase
   end

   // Decisions look at the sample being registered this edge, so a dwell of
   // SETTLE samples is captured on its SETTLE-th edge (SETTLE=1 on the first).
   always_comb begin
      s_seg_d  = seg;
      s_an_d   = an;
      changed  = ({s_an_d, s_seg_d} != {s_an_q, s_seg_q});
      slot_oh  = ~s_an_d;
      legal    = $onehot(slot_oh);

      if (changed)             cnt_d = '0;
      else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
      else                     cnt_d = cnt_q + 8'd1;

      capture = legal && (cnt_d == CNT_CAP) && (changed || state_q == SETTLING);

      if (capture)      state_d = HELD;
      else if (changed) state_d = legal ? SETTLING : IDLE;
      else              state_d = state_q;

      work_d     = work_q;
      wblank_d   = wblank_q;
      seen_d     = seen_q;
      scan_err_d = scan_err_q;
      value_d    = value_q;
      blank_d    = blank_q;
      err_d      = err_q;
      valid_d    = 1'b0;
      seen_all   = seen_q | slot_oh;

      if (capture) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (slot_oh[i]) begin
               work_d[i*4 +: 4] = dec_nib;
               wblank_d[i]      = dec_blank;
            end
         end
         seen_d     = seen_all;
         scan_err_d = scan_err_q | dec_bad;
         if (seen_all == 4'b1111) begin
            value_d    = work_d;
            blank_d    = wblank_d;
            err_d      = scan_err_d;
            valid_d    = 1'b1;
            seen_d     = '0;
            scan_err_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         s_seg_q    <= 7'h7F;
         s_an_q     <= 4'hF;
         cnt_q      <= '0;
         seen_q     <= '0;
         work_q     <= '0;
         wblank_q   <= '0;
         scan_err_q <= 1'b0;
         value_q    <= '0;
         blank_q    <= '0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_seg_q    <= s_seg_d;
         s_an_q     <= s_an_d;
         cnt_q      <= cnt_d;
         seen_q     <= seen_d;
         work_q     <= work_d;
         wblank_q   <= wblank_d;
         scan_err_q <= scan_err_d;
         value_q    <= value_d;
         blank_q    <= blank_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
      end
   end

   assign value = value_q;
   assign blank = blank_q;
   assign err   = err_q;
   assign valid = valid_q;

endmodule
